// File: rtl/qarma128_pkg.sv
// Shared definitions for the QARMA-128 key ingest path: widths, the loader
// state encoding and the hexPi constant used by key specialisation.
package qarma128_pkg;

    localparam int N         = 128;
    localparam int KEY_W     = 256;
    localparam int WORD_W    = 64;
    localparam int NUM_WORDS = 4;

    // First 128 bits of the fractional part of pi, XORed into k0 for decryption.
    localparam logic [N-1:0] HEX_PI = 128'h243F6A8885A308D313198A2E03707344;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SPEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/qarma128_key_loader_key_spec.sv
// key_spec: combinational key specialisation for QARMA-128.
// key[N+:N] is the whitening key w0, key[0+:N] is the core key k0.
// Encrypt: w0, w1 = o(w0), k0, k1 = k0.
// Decrypt: w0 = o(w0), w1 = w0, k0 = k0 ^ hexPi, k1 = MixColumns(k0).
// The state is 16 byte cells, cell i at bits [N-1-8i -: 8], row = i/4, col = i%4.
module key_spec
    import qarma128_pkg::*;
(
    input  logic             enc,
    input  logic [KEY_W-1:0] key,
    output logic [N-1:0]     w0,
    output logic [N-1:0]     w1,
    output logic [N-1:0]     k0,
    output logic [N-1:0]     k1
);

    // Orthomorphism o(x) = (x >>> 1) ^ (x >> (N-1)).
    function automatic logic [N-1:0] ortho(input logic [N-1:0] x);
        logic [N-1:0] rot;
        logic [N-1:0] msb;
        rot = {x[0], x[N-1:1]};
        msb = '0;
        msb[0] = x[N-1];
        return rot ^ msb;
    endfunction

    // Circulant coefficient sel: 0 -> zero, 1 -> rho1, 2 -> rho4, 3 -> rho5.
    function automatic logic [7:0] cell_mul(input logic [7:0] c, input logic [1:0] sel);
        logic [7:0] r;
        case (sel)
            2'd1:    r = {c[6:0], c[7]};
            2'd2:    r = {c[3:0], c[7:4]};
            2'd3:    r = {c[2:0], c[7:3]};
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    // MixColumns with M = circ(0, rho1, rho4, rho5) applied per column.
    function automatic logic [N-1:0] mix_columns(input logic [N-1:0] x);
        logic [N-1:0] y;
        logic [7:0]   acc;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'd0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ cell_mul(x[N-8-8*(4*k+c) +: 8], 2'((k - r) & 3));
                end
                y[N-8-8*(4*r+c) +: 8] = acc;
            end
        end
        return y;
    endfunction

    logic [N-1:0] w_w0_base;
    logic [N-1:0] w_k0_base;
    logic [N-1:0] w_w0_orth;

    assign w_w0_base = key[N +: N];
    assign w_k0_base = key[0 +: N];
    assign w_w0_orth = ortho(w_w0_base);

    // Select the encrypt or decrypt form of the specialised keys.
    always_comb begin
        w0 = w_w0_base;
        w1 = w_w0_orth;
        k0 = w_k0_base;
        k1 = w_k0_base;
        if (!enc) begin
            w0 = w_w0_orth;
            w1 = w_w0_base;
            k0 = w_k0_base ^ HEX_PI;
            k1 = mix_columns(w_k0_base);
        end
    end

endmodule

// File: rtl/qarma128_key_loader.sv
// qarma128_key_loader: assembles a 256-bit master key from four 64-bit words,
// runs it through key_spec and holds w0/w1/k0/k1 until the consumer acks.
// Optional build macro QARMA_KEY_ZEROIZE_EN: the ack also clears the key
// register, w0/w1/k0/k1 and enc_o.
// Handshakes: a word transfers on a rising edge where key_word_valid and
// key_word_ready are both high; the key transfers on a rising edge where
// key_valid and key_ack are both high. key_ack outside HOLD has no effect.
module qarma128_key_loader
    import qarma128_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enc,
    input  logic [WORD_W-1:0] key_word,
    input  logic              key_word_valid,
    output logic              key_word_ready,
    output logic              key_valid,
    input  logic              key_ack,
    output logic              enc_o,
    output logic [N-1:0]      w0,
    output logic [N-1:0]      w1,
    output logic [N-1:0]      k0,
    output logic [N-1:0]      k1
);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_cnt;
    logic [KEY_W-1:0] r_key;
    logic             r_enc;
    logic             r_enc_o;
    logic [N-1:0]     r_w0, r_w1, r_k0, r_k1;
    logic [N-1:0]     w_w0, w_w1, w_k0, w_k1;
    logic             w_word_hs;
    logic             w_key_hs;
    logic             w_ready;
    logic             w_valid;

    key_spec u_key_spec (
        .enc (r_enc),
        .key (r_key),
        .w0  (w_w0),
        .w1  (w_w1),
        .k0  (w_k0),
        .k1  (w_k1)
    );

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_ready = 1'b1;
                if (key_word_valid && r_cnt == 2'(NUM_WORDS - 1)) begin
                    w_next_state = ST_SPEC;
                end
            end
            ST_SPEC: begin
                w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                if (key_ack) begin
                    w_next_state = ST_LOAD;
                end
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    assign w_word_hs = key_word_valid & w_ready;
    assign w_key_hs  = key_ack & w_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Word capture, mode latch, specialised-key registers and optional zeroize.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_key   <= '0;
            r_enc   <= 1'b0;
            r_enc_o <= 1'b0;
            r_w0    <= '0;
            r_w1    <= '0;
            r_k0    <= '0;
            r_k1    <= '0;
        end else begin
            if (w_word_hs) begin
                r_key[int'(r_cnt)*WORD_W +: WORD_W] <= key_word;
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd0) begin
                    r_enc <= enc;
                end
            end
            if (r_state == ST_SPEC) begin
                r_w0    <= w_w0;
                r_w1    <= w_w1;
                r_k0    <= w_k0;
                r_k1    <= w_k1;
                r_enc_o <= r_enc;
            end
`ifdef QARMA_KEY_ZEROIZE_EN
            if (w_key_hs) begin
                r_key   <= '0;
                r_w0    <= '0;
                r_w1    <= '0;
                r_k0    <= '0;
                r_k1    <= '0;
                r_enc_o <= 1'b0;
            end
`else
            if (w_key_hs) begin
                r_enc_o <= r_enc_o;
            end
`endif
        end
    end

    assign key_word_ready = w_ready;
    assign key_valid      = w_valid;
    assign enc_o          = r_enc_o;
    assign w0             = r_w0;
    assign w1             = r_w1;
    assign k0             = r_k0;
    assign k1             = r_k1;

endmodule
